// File: rtl/joyport_pkg.sv
// rtl/joyport_pkg.sv - shared types, mode encodings and defaults for the joystick/mouse port arbiter
package joyport_pkg;

    typedef enum logic [1:0] {
        ST_JOY        = 2'd0,
        ST_PEND_MOUSE = 2'd1,
        ST_MOUSE      = 2'd2,
        ST_PEND_JOY   = 2'd3
    } joy_state_t;

    localparam logic [1:0] MODE_AUTO  = 2'b00;
    localparam logic [1:0] MODE_JOY   = 2'b01;
    localparam logic [1:0] MODE_MOUSE = 2'b10;

    // ~100 us of strobe silence at 21.48 MHz
    localparam int GUARD_CYCLES_DEFAULT = 2148;

    // Both 00 and 11 select automatic arbitration.
    function automatic logic is_auto(input logic [1:0] mode);
        return (mode != MODE_JOY) && (mode != MODE_MOUSE);
    endfunction

    // Gamepad {f2,f1,up,down,left,right} active-high -> port pins {f2,f1,right,left,down,up} active-low.
    function automatic logic [5:0] joy_to_port(input logic [5:0] joy);
        return ~{joy[5], joy[4], joy[0], joy[1], joy[2], joy[3]};
    endfunction

endpackage

// File: rtl/strobe_quiet_timer.sv
// rtl/strobe_quiet_timer.sv - strobe edge detector with a saturating quiet-interval counter
module strobe_quiet_timer
    import joyport_pkg::*;
#(
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic strobe,
    input  logic restart,
    output logic quiet
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GUARD_CYCLES);

    logic             strobe_prev;
    logic [CNT_W-1:0] quiet_cnt;
    logic             strobe_edge;

    assign strobe_edge = strobe ^ strobe_prev;
    assign quiet       = (quiet_cnt == CNT_MAX);

    // restart lets the arbiter measure a fresh interval from the moment a switch is requested
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            strobe_prev <= 1'b0;
            quiet_cnt   <= '0;
        end else begin
            strobe_prev <= strobe;
            if (strobe_edge || restart)
                quiet_cnt <= '0;
            else if (quiet_cnt != CNT_MAX)
                quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/joyport_arbiter.sv
// rtl/joyport_arbiter.sv - hands MSX joystick port A to either a gamepad or a PS/2 mouse during strobe silence
module joyport_arbiter
    import joyport_pkg::*;
#(
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [5:0] joy,
    input  logic [5:0] mouse_data,
    input  logic       mouse_act,
    input  logic       port_str,
    output logic [5:0] port_data,
    output logic       mouse_str,
    output logic       use_mouse
);

    joy_state_t state;
    joy_state_t state_next;

    logic [5:0] joy_q;
    logic       mouse_act_q;
    logic       port_str_q;

    logic       joy_req;
    logic       mouse_req;
    logic       auto_mode;
    logic       quiet;
    logic       restart;
    logic       mouse_owner;
    logic [5:0] port_data_next;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_q       <= '0;
            mouse_act_q <= 1'b0;
            port_str_q  <= 1'b0;
        end else begin
            joy_q       <= joy;
            mouse_act_q <= mouse_act;
            port_str_q  <= port_str;
        end
    end

    assign joy_req   = |joy_q;
    assign mouse_req = ~mouse_act_q;
    assign auto_mode = is_auto(mode);

    assign restart = ((state == ST_JOY)   && (state_next == ST_PEND_MOUSE)) ||
                     ((state == ST_MOUSE) && (state_next == ST_PEND_JOY));

    strobe_quiet_timer #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_quiet (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (port_str_q),
        .restart (restart),
        .quiet   (quiet)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= ST_JOY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_JOY: begin
                if (mode == MODE_MOUSE)
                    state_next = ST_PEND_MOUSE;
                else if (auto_mode && mouse_req && !joy_req)
                    state_next = ST_PEND_MOUSE;
            end
            // A mouse request that vanishes before the handover is dropped, so the
            // reset value of the mouse_act register cannot cause a stray switch.
            ST_PEND_MOUSE: begin
                if (mode == MODE_JOY)
                    state_next = ST_JOY;
                else if (auto_mode && (joy_req || !mouse_req))
                    state_next = ST_JOY;
                else if (quiet)
                    state_next = ST_MOUSE;
            end
            ST_MOUSE: begin
                if ((mode == MODE_JOY) || (auto_mode && joy_req))
                    state_next = ST_PEND_JOY;
            end
            ST_PEND_JOY: begin
                if (mode == MODE_MOUSE)
                    state_next = ST_MOUSE;
                else if (quiet)
                    state_next = ST_JOY;
            end
            default: state_next = ST_JOY;
        endcase
    end

    always_comb begin
        mouse_owner    = (state == ST_MOUSE) || (state == ST_PEND_JOY);
        port_data_next = mouse_owner ? mouse_data : joy_to_port(joy_q);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            port_data <= 6'h3F;
            use_mouse <= 1'b0;
        end else begin
            port_data <= port_data_next;
            use_mouse <= mouse_owner;
        end
    end

    assign mouse_str = use_mouse & port_str_q;

endmodule
